// File: rtl/writeback_unit_pkg.sv
// Shared core constants: write-back source selects and
// write-back controller state encodings.
package writeback_unit_pkg;

  typedef enum logic [3:0] {
    WB_ALU   = 4'd0,
    WB_MEMB  = 4'd1,
    WB_MEMBU = 4'd2,
    WB_MEMH  = 4'd3,
    WB_MEMHU = 4'd4,
    WB_MEMW  = 4'd5,
    WB_MEMWU = 4'd6,
    WB_MEMD  = 4'd7,
    WB_PC    = 4'd8,
    WB_CSR   = 4'd9
  } wb_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    HALT     = 2'd2
  } wb_state_e;

endpackage

// File: rtl/writeback_unit_load_align.sv
// Load data extraction: picks byte/half/word at the load
// offset and sign- or zero-extends it to XLEN.
module wb_load_align
  import writeback_unit_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [OW-1:0]   off,
  input  logic [3:0]      sel,
  output logic [XLEN-1:0] data
);

  logic [OW-1:0] hoff;
  logic [OW-1:0] woff;
  logic [7:0]    b8;
  logic [15:0]   h16;
  logic [31:0]   w32;

  // Halfword/word accesses ignore the sub-alignment offset bits.
  assign hoff = off & ~OW'(1);
  assign woff = off & ~OW'(3);
  assign b8   = rdata[{off, 3'b000} +: 8];
  assign h16  = rdata[{hoff, 3'b000} +: 16];
  assign w32  = rdata[{woff, 3'b000} +: 32];

  always_comb begin
    data = rdata;
    case (wb_sel_e'(sel))
      WB_MEMB:  data = XLEN'($signed(b8));
      WB_MEMBU: data = XLEN'(b8);
      WB_MEMH:  data = XLEN'($signed(h16));
      WB_MEMHU: data = XLEN'(h16);
      WB_MEMW:  data = XLEN'($signed(w32));
      WB_MEMWU: data = XLEN'(w32);
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: register file with bypassed read ports,
// retire counter and redirect/halt controller.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter logic [XLEN-1:0] EXIT_PC = XLEN'(32'hffffff00),
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'h00002000),
  localparam int AW = $clog2(NREG),
  localparam int OW = $clog2(XLEN / 8)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic [XLEN-1:0] in_csr_rdata,
  input  logic [XLEN-1:0] in_br_target,
  input  logic [XLEN-1:0] in_trap_vector,
  input  logic [3:0]      in_wb_sel,
  input  logic [OW-1:0]   in_mem_off,
  input  logic [AW-1:0]   in_wb_addr,
  input  logic            in_rf_wen,
  input  logic            in_br_flg,
  input  logic            in_jmp_flg,
  input  logic            in_trap,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [63:0]     instret,
  output logic            exit
);

  wb_state_e       state, state_nxt;
  logic [XLEN-1:0] rf [NREG];
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] redir_nxt;
  logic            accept;
  logic            wr_en;
  logic            redir_req;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .rdata (in_mem_rdata),
    .off   (in_mem_off),
    .sel   (in_wb_sel),
    .data  (load_data)
  );

  assign in_ready       = (state == RUN);
  assign redirect_valid = (state == REDIRECT);
  assign exit           = (state == HALT);
  assign accept    = in_valid & in_ready;
  assign wr_en     = accept & in_rf_wen & (in_wb_addr != '0);
  assign redir_req = in_br_flg | in_jmp_flg | in_trap;

  always_comb begin
    wr_data = in_alu_out;
    case (wb_sel_e'(in_wb_sel))
      WB_MEMB, WB_MEMBU, WB_MEMH, WB_MEMHU,
      WB_MEMW, WB_MEMWU, WB_MEMD:
        wr_data = load_data;
      WB_PC:   wr_data = in_pc + XLEN'(4);
      WB_CSR:  wr_data = in_csr_rdata;
      default: wr_data = in_alu_out;
    endcase
  end

  always_comb begin
    redir_nxt = in_trap_vector;
    if (in_br_flg)
      redir_nxt = in_br_target;
    else if (in_jmp_flg)
      redir_nxt = {in_alu_out[XLEN-1:1], 1'b0};
  end

  // Halting at EXIT_PC takes priority over any redirect.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (accept && in_pc == EXIT_PC)
          state_nxt = HALT;
        else if (accept && redir_req)
          state_nxt = REDIRECT;
      end
      REDIRECT: state_nxt = RUN;
      HALT:     state_nxt = HALT;
      default:  state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      redirect_pc <= '0;
      instret     <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        instret <= instret + 64'd1;
      if (accept && redir_req)
        redirect_pc <= redir_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= (i == 2) ? SP_INIT : '0;
    end else if (wr_en) begin
      rf[in_wb_addr] <= wr_data;
    end
  end

  always_comb begin
    rs1_data = rf[rs1_addr];
    if (wr_en && in_wb_addr == rs1_addr)
      rs1_data = wr_data;
    if (rs1_addr == '0)
      rs1_data = '0;
  end

  always_comb begin
    rs2_data = rf[rs2_addr];
    if (wr_en && in_wb_addr == rs2_addr)
      rs2_data = wr_data;
    if (rs2_addr == '0)
      rs2_data = '0;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The module SHALL take parameter XLEN, default 32, meaning datapath width (32 or 64).
REQ-002 The module SHALL take parameter NREG, default 32, meaning architectural register count (16 for RV32E, or 32).
REQ-003 The module SHALL take parameter EXIT_PC, default 32'hffffff00, meaning the PC whose retirement halts the core.
REQ-004 The module SHALL take parameter SP_INIT, default 32'h00002000, meaning the reset value of x2.
REQ-005 The module SHALL use one clock, clk, input, 1 bit, and SHALL treat all state as rising-edge.
REQ-006 The module SHALL use rst_n, input, 1 bit, as an asynchronous, active-low reset.
REQ-007 in_valid/in_ready SHALL be input/output, 1 bit each: instruction-present / unit-accepts.
REQ-008 in_pc, in_alu_out, in_mem_rdata, in_csr_rdata, in_br_target and in_trap_vector SHALL be inputs, XLEN bits each.
REQ-009 in_wb_sel SHALL be input, 4 bits (write-back source); in_mem_off SHALL be input, log2(XLEN/8) bits (load byte offset).
REQ-010 in_wb_addr SHALL be input, log2(NREG) bits; in_rf_wen, in_br_flg, in_jmp_flg and in_trap SHALL be inputs, 1 bit each.
REQ-011 rs1_addr/rs2_addr SHALL be inputs, log2(NREG) bits; rs1_data/rs2_data SHALL be outputs, XLEN bits (decode read ports).
REQ-012 redirect_valid SHALL be output, 1 bit, and redirect_pc SHALL be output, XLEN bits (fetch redirect).
REQ-013 instret SHALL be output, 64 bits (retired count), and exit SHALL be output, 1 bit (halted).

Function
REQ-014 An instruction SHALL be accepted on a clock edge where in_valid && in_ready; all other input cycles are ignored.
REQ-015 The state machine SHALL have states RUN, REDIRECT and HALT; in_ready SHALL be 1 only in RUN.
REQ-016 On accept with in_rf_wen=1 and in_wb_addr!=0, the register SHALL be written at that edge; writes to x0 SHALL be dropped, and x0 SHALL always read 0.
REQ-017 Write data by in_wb_sel SHALL be: MEMB/MEMBU = byte at in_mem_off, sign/zero-extended; MEMH/MEMHU = halfword at in_mem_off with bit0 ignored; MEMW/MEMWU = word (MEMWU zero-extends; in XLEN=32 both are identity); MEMD = full XLEN (XLEN=64 only, else as MEMW); PC = in_pc+4 mod 2^XLEN; CSR = in_csr_rdata; otherwise in_alu_out.
REQ-018 Read ports SHALL be combinational, with same-cycle bypass: if an accepted write targets rsN_addr (non-zero), rsN_data SHALL equal the write data.
REQ-019 instret SHALL increment by 1 on every accept, wrapping at 2^64.
REQ-020 An accept in RUN with any of in_br_flg, in_jmp_flg or in_trap SHALL move to REDIRECT.
REQ-021 In REDIRECT, redirect_valid SHALL be 1 for exactly one cycle, and the state SHALL then return to RUN.
REQ-022 redirect_pc SHALL be selected with priority br (in_br_target) > jmp (in_alu_out with bit0 cleared) > trap (in_trap_vector), captured at the accept.
REQ-023 An accept with in_pc==EXIT_PC SHALL still write and count, and SHALL then enter HALT; HALT overrides any redirect.
REQ-024 In HALT, exit SHALL be 1, and in_ready and redirect_valid SHALL be 0; HALT SHALL be left only by reset.
REQ-025 redirect_valid SHALL be 0 in every cycle outside REDIRECT.

Reset
REQ-026 On rst_n=0 (asynchronous), all registers SHALL clear to 0 except x2=SP_INIT, state SHALL become RUN, instret SHALL become 0, and redirect_valid, redirect_pc and exit SHALL become 0.
REQ-027 A reset asserted during REDIRECT or HALT SHALL drop the pending redirect immediately, and no write SHALL occur in the reset cycle.
REQ-028 Release of reset SHALL be synchronised by the integrator, and in_ready SHALL be 1 in the first cycle after release.

Structure
REQ-029 The wb_sel encodings (MEMB, MEMBU, MEMH, MEMHU, MEMW, MEMWU, MEMD, PC, CSR, ALU) and the state encodings SHALL live in the shared core constants package.
REQ-030 Load extraction and extension SHALL be a combinational sub-module, wb_load_align (XLEN parameter; inputs rdata, off, sel; output data).
REQ-031 The register file, bypass, FSM and counter SHALL reside in writeback_unit.

Verification
REQ-032 XLEN=32; accept MEMB, off=2, rdata=32'h12_80_34_56, wb_addr=5 -> x5=32'hffffff80, and rs1_addr=5 in the same cycle reads 32'hffffff80.
REQ-033 Accept rf_wen=1, wb_addr=0, ALU=32'hdead -> rs1_addr=0 reads 0, and instret increments by 1.
REQ-034 Accept jmp_flg=1, alu_out=32'h1003 -> next cycle redirect_valid=1 with redirect_pc=32'h1002, and in_ready=0 that cycle; the following cycle redirect_valid=0 and in_ready=1.
REQ-035 Accept br_flg=1 and trap=1 together, br_target=32'h200, trap_vector=32'h800 -> redirect_pc=32'h200.
REQ-036 Accept in_pc=EXIT_PC with br_flg=1 and WB_PC to x1 -> x1=32'hffffff04, exit=1, no redirect_valid, and in_ready held 0 until rst_n pulse.
REQ-037 XLEN=64, NREG=16; assert rst_n=0 mid-REDIRECT -> redirect_valid drops at once, x2=SP_INIT and instret=0; then MEMWU, off=4, rdata=64'hffff0000_00000000 -> data 64'h00000000_ffff0000.
